// File: rtl/simon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_pkg                                                                |
// | Shared constants, types and helpers for the Simon key-schedule block.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package simon_pkg;

  // Character j of each z-sequence (counted from the left) lives at bit 61-j.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  function automatic logic [61:0] z_seq(input int sel);
    case (sel)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

  // Word width / key word pairs that exist in the Simon family.
  function automatic bit legal_cfg(input int w, input int m);
    case (w)
      16:      return (m == 4);
      24:      return (m == 3) || (m == 4);
      32:      return (m == 3) || (m == 4);
      48:      return (m == 2) || (m == 3);
      64:      return (m == 2) || (m == 3) || (m == 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int amt, input int w);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = x & mask;
    return ((v >> amt) | (v << (w - amt))) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_ks_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_ks_round                                                           |
// | Combinational Simon key-schedule step: derives k[i] from the window.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module simon_ks_round
  import simon_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic [WORD_W-1:0] k_im1_i,
  input  logic [WORD_W-1:0] k_im3_i,
  input  logic [WORD_W-1:0] k_im_i,
  input  logic              z_i,
  output logic [WORD_W-1:0] k_o
);

  logic [WORD_W-1:0] w_k3_mask;
  logic [WORD_W-1:0] w_tmp;

  // k[i-3] only participates for four-word keys.
  assign w_k3_mask = (KEY_WORDS == 4) ? '1 : '0;
  assign w_tmp     = WORD_W'(ror(64'(k_im1_i), 3, WORD_W)) ^ (k_im3_i & w_k3_mask);
  assign k_o       = ~k_im_i ^ w_tmp ^ WORD_W'(ror(64'(w_tmp), 1, WORD_W))
                     ^ WORD_W'(3) ^ WORD_W'(z_i);

endmodule
`default_nettype wire

// File: rtl/simon_key_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_key_expand                                                         |
// | Simon round-key expansion into a buffer with a registered read port.     |
// | Optional stream port: define SIMON_KS_STREAM_EN.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module simon_key_expand
  import simon_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 44,
  parameter int Z_SEL     = 3,
  parameter int IDX_W     = $clog2(ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  output logic                        busy,
  output logic                        done,
  output logic                        keys_valid,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [WORD_W-1:0]           rd_data
`ifdef SIMON_KS_STREAM_EN
  ,
  output logic                        rk_valid,
  input  logic                        rk_ready,
  output logic [WORD_W-1:0]           rk_data,
  output logic [IDX_W-1:0]            rk_idx
`endif
);

  localparam logic [61:0]      C_Z         = z_seq(Z_SEL);
  localparam logic [IDX_W-1:0] C_LAST_LOAD = IDX_W'(KEY_WORDS - 1);
  localparam logic [IDX_W-1:0] C_LAST      = IDX_W'(ROUNDS - 1);
  localparam int               WIN_AW      = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  if (!legal_cfg(WORD_W, KEY_WORDS)) begin : g_bad_word_cfg
    $error("simon_key_expand: illegal WORD_W/KEY_WORDS combination");
  end
  if (ROUNDS <= KEY_WORDS) begin : g_bad_rounds
    $error("simon_key_expand: ROUNDS must exceed KEY_WORDS");
  end
  if ((Z_SEL < 0) || (Z_SEL > 4)) begin : g_bad_zsel
    $error("simon_key_expand: Z_SEL must be 0..4");
  end

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   win_q [KEY_WORDS];
  logic [WORD_W-1:0]   win_d [KEY_WORDS];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [5:0]          zcnt_q, zcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                kv_q, kv_d;
  logic [WORD_W-1:0]   rd_data_q;
  logic [WORD_W-1:0]   rk_buf_q [ROUNDS];

  logic                w_rk_ready;
  logic                w_adv;
  logic                w_zbit;
  logic [WORD_W-1:0]   w_k_im3;
  logic [WORD_W-1:0]   w_next_word;
  logic [WORD_W-1:0]   w_cur_word;
  logic [WIN_AW-1:0]   w_win_sel;

`ifdef SIMON_KS_STREAM_EN
  assign w_rk_ready = rk_ready;
  assign rk_valid   = (state_q != ST_IDLE);
  assign rk_data    = w_cur_word;
  assign rk_idx     = idx_q;
`else
  assign w_rk_ready = 1'b1;
`endif

  if (KEY_WORDS == 4) begin : g_k3_tap
    assign w_k_im3 = win_q[1];
  end else begin : g_k3_none
    assign w_k_im3 = win_q[0];
  end

  assign w_adv     = (state_q != ST_IDLE) && w_rk_ready;
  assign w_zbit    = C_Z[6'd61 - zcnt_q];
  assign w_win_sel = idx_q[WIN_AW-1:0];

  simon_ks_round #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_round (
    .k_im1_i (win_q[KEY_WORDS-1]),
    .k_im3_i (w_k_im3),
    .k_im_i  (win_q[0]),
    .z_i     (w_zbit),
    .k_o     (w_next_word)
  );

  // During LOAD the master-key words pass straight from the window.
  assign w_cur_word = (state_q == ST_LOAD) ? win_q[w_win_sel] : w_next_word;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    zcnt_d  = zcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d = ST_LOAD;
          for (int j = 0; j < KEY_WORDS; j++) begin
            win_d[j] = key_in[j*WORD_W +: WORD_W];
          end
          idx_d  = '0;
          zcnt_d = '0;
          kv_d   = 1'b0;
          busy_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_adv) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == C_LAST_LOAD) begin
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (w_adv) begin
          for (int j = 0; j < KEY_WORDS - 1; j++) begin
            win_d[j] = win_q[j+1];
          end
          win_d[KEY_WORDS-1] = w_next_word;
          zcnt_d = (zcnt_q == 6'd61) ? 6'd0 : zcnt_q + 6'd1;
          idx_d  = idx_q + 1'b1;
          if (idx_q == C_LAST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            kv_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      for (int j = 0; j < KEY_WORDS; j++) begin
        win_q[j] <= '0;
      end
      idx_q  <= '0;
      zcnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      kv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      zcnt_q  <= zcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      rk_buf_q[idx_q] <= w_cur_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (int'(rd_addr) < ROUNDS) begin
      rd_data_q <= rk_buf_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_key_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_simon_key_expand                                                      |
// | Randomised bench for simon_key_expand against a string-driven model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_simon_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         start_a, start_b;
  logic [127:0] key_a;
  logic [63:0]  key_b;
  logic         busy_a, done_a, kv_a;
  logic         busy_b, done_b, kv_b;
  logic [5:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic [31:0]  rd_data_a;
  logic [15:0]  rd_data_b;
`ifdef SIMON_KS_STREAM_EN
  logic         rk_valid_a, rk_ready_a, rk_valid_b, rk_ready_b;
  logic [31:0]  rk_data_a;
  logic [5:0]   rk_idx_a;
  logic [15:0]  rk_data_b;
  logic [4:0]   rk_idx_b;
`endif

  simon_key_expand u_dut_a (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start_a),
    .key_in     (key_a),
    .busy       (busy_a),
    .done       (done_a),
    .keys_valid (kv_a),
    .rd_addr    (rd_addr_a),
    .rd_data    (rd_data_a)
`ifdef SIMON_KS_STREAM_EN
    ,
    .rk_valid   (rk_valid_a),
    .rk_ready   (rk_ready_a),
    .rk_data    (rk_data_a),
    .rk_idx     (rk_idx_a)
`endif
  );

  simon_key_expand #(
    .WORD_W    (16),
    .KEY_WORDS (4),
    .ROUNDS    (32),
    .Z_SEL     (0)
  ) u_dut_b (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start_b),
    .key_in     (key_b),
    .busy       (busy_b),
    .done       (done_b),
    .keys_valid (kv_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b)
`ifdef SIMON_KS_STREAM_EN
    ,
    .rk_valid   (rk_valid_b),
    .rk_ready   (rk_ready_b),
    .rk_data    (rk_data_b),
    .rk_idx     (rk_idx_b)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] gold [64];

  localparam logic [127:0] C_KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  C_KEYB = 64'h1918_1110_0908_0100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned rot_r(input longint unsigned x, input int r, input int n);
    longint unsigned mask;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    x    = x & mask;
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Reference schedule straight from the Simon definition, z taken as text.
  task automatic model_ks(input logic [255:0] key, input int n, input int m, input int t, input int zsel);
    string           zs;
    longint unsigned mask, tmp, zb;
    byte             ch;
    case (zsel)
      0:       zs = "11111010001001010110000111001101111101000100101011000011100110";
      1:       zs = "10001110111110010011000010110101000111011111001001100001011010";
      2:       zs = "10101111011100000011010010011000101000010001111110010110110011";
      3:       zs = "11011011101011000110010111100000010010001010011100110100001111";
      default: zs = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < t; i++) begin
      if (i < m) begin
        gold[i] = 64'(key >> (i * n)) & mask;
      end else begin
        tmp = rot_r(gold[i-1], 3, n);
        if (m == 4) tmp = tmp ^ gold[i-3];
        ch = zs[(i - m) % 62];
        zb = (ch == 8'h31) ? 64'd1 : 64'd0;
        gold[i] = (~gold[i-m] & mask) ^ tmp ^ rot_r(tmp, 1, n) ^ zb ^ 64'd3;
      end
    end
  endtask

  task automatic read_a(input int addr, output logic [31:0] d);
    @(negedge clk);
    rd_addr_a = 6'(addr);
    @(posedge clk);
    #1;
    d = rd_data_a;
  endtask

  task automatic sweep_a(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 44; a++) begin
      read_a(a, d);
      check($sformatf("%s_rd[%0d]", tag, a), d, gold[a]);
    end
    read_a(44, d);
    check($sformatf("%s_rd_oor44", tag), d, 0);
    read_a(63, d);
    check($sformatf("%s_rd_oor63", tag), d, 0);
  endtask

  // repulse: extra starts at cycles 5 and 20; done_start: start held in the done cycle.
  task automatic run_a(input logic [127:0] key, input bit repulse, input bit done_start);
    int lat;
    @(negedge clk);
    key_a   = key;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    lat     = 1;
    check("busy_after_start", busy_a, 1);
    check("kv_cleared", kv_a, 0);
    while (!done_a && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start_a = repulse && (lat == 5 || lat == 20);
    end
    check("done_latency", lat, 45);
    check("kv_after_done", kv_a, 1);
    check("busy_after_done", busy_a, 0);
    start_a = done_start;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("done_single_pulse", done_a, 0);
    check("idle_after_done", busy_a, 0);
  endtask

  task automatic run_b(input logic [63:0] key);
    int          lat;
    logic [15:0] d;
    @(negedge clk);
    key_b   = key;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    lat     = 1;
    while (!done_b && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b_done_latency", lat, 33);
    check("b_kv_after_done", kv_b, 1);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr_b = 5'(a);
      @(posedge clk);
      #1;
      d = rd_data_b;
      check($sformatf("b_rd[%0d]", a), d, gold[a]);
    end
  endtask

`ifdef SIMON_KS_STREAM_EN
  task automatic run_stream(input logic [127:0] key);
    int          n_xfer = 0;
    int          cyc    = 0;
    bit          stalled = 1'b0;
    logic [31:0] pd;
    logic [5:0]  pi;
    @(negedge clk);
    key_a      = key;
    start_a    = 1'b1;
    rk_ready_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    while (!done_a && cyc < 400) begin
      rk_ready_a = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      if (rk_valid_a) begin
        if (stalled) begin
          check("rk_data_hold", rk_data_a, pd);
          check("rk_idx_hold", rk_idx_a, pi);
        end
        if (rk_ready_a) begin
          check("rk_idx_order", rk_idx_a, n_xfer);
          check($sformatf("rk_data[%0d]", n_xfer), rk_data_a, gold[n_xfer % 64]);
          n_xfer++;
        end
        stalled = !rk_ready_a;
        pd      = rk_data_a;
        pi      = rk_idx_a;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rk_ready_a = 1'b1;
    check("rk_xfer_count", n_xfer, 44);
    check("rk_done_seen", done_a, 1);
  endtask
`endif

  initial begin
    logic [31:0]  d;
    logic [127:0] rk;
    logic [63:0]  rkb;

    rstn      = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    key_a     = '0;
    key_b     = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
`ifdef SIMON_KS_STREAM_EN
    rk_ready_a = 1'b1;
    rk_ready_b = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_kv", kv_a, 0);
    check("rst_rd_data", rd_data_a, 0);
    rstn = 1'b1;

    // Reference schedule for Simon 64/128 with the published key.
    model_ks(256'(C_KEY1), 32, 4, 44, 3);
    run_a(C_KEY1, 1'b0, 1'b0);
    read_a(0, d);
    check("t1_k0", d, 32'h03020100);
    read_a(3, d);
    check("t1_k3", d, 32'h1b1a1918);
    read_a(4, d);
    check("t1_k4", d, 32'h70a011c3);
    sweep_a("t1");

    // Ignored starts mid-run and in the done cycle.
    run_a(C_KEY1, 1'b1, 1'b1);
    sweep_a("t3");

    // Reset in the middle of expansion, then a clean rerun.
    @(negedge clk);
    key_a   = C_KEY1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_busy_pre", busy_a, 1);
    rstn = 1'b0;
    #1;
    check("t4_busy_rst", busy_a, 0);
    check("t4_kv_rst", kv_a, 0);
    check("t4_rd_rst", rd_data_a, 0);
    @(negedge clk);
    rstn = 1'b1;
    run_a(C_KEY1, 1'b0, 1'b0);
    sweep_a("t4");

    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_ks(256'(rk), 32, 4, 44, 3);
      run_a(rk, 1'b0, 1'b0);
      sweep_a($sformatf("rnd%0d", r));
    end

    // Simon 32/64 instance.
    model_ks(256'(C_KEYB), 16, 4, 32, 0);
    run_b(C_KEYB);
    for (int r = 0; r < 2; r++) begin
      rkb = {$urandom, $urandom};
      model_ks(256'(rkb), 16, 4, 32, 0);
      run_b(rkb);
    end

`ifdef SIMON_KS_STREAM_EN
    model_ks(256'(C_KEY1), 32, 4, 44, 3);
    run_stream(C_KEY1);
    sweep_a("t6");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
